rr_arbiter8: RTL and testbench

//  Round-robin arbiter that shares one resource among NREQ requesters and drives
//  a one-hot grant vector to the shared resource, plus the matching binary grant index.
//  It sits in front of the shared resource, which is selected by the index or the one-hot vector.

---
 rtl/rr_arbiter8_if.sv | 38 +++
 rtl/rr_arbiter8.sv | 179 +++++++++++++++++
 tb/tb_rr_arbiter8.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter8_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter8_if
//   Bundle of the request/grant signals between the requesters and the
//   round-robin arbiter. Clock and reset are kept outside the bundle.
//
//   en          requester side -> arbiter : arbitration enable
//   req         requester side -> arbiter : one request bit per requester
//   done        requester side -> arbiter : current owner finished
//   grant       arbiter -> requester side : one-hot grant, zero when idle
//   grant_id    arbiter -> requester side : binary index of the owner
//   grant_valid arbiter -> requester side : a grant is active
//   timeout     arbiter -> requester side : pulse on forced release
//
//   master : the requester side (drives en/req/done)
//   slave  : the arbiter (drives the grant outputs)
// ---------------------------------------------------------------------------
interface rr_arbiter8_if #(
    parameter int NREQ = 8,
    parameter int IDW  = 3
);
    logic            en;
    logic [NREQ-1:0] req;
    logic            done;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_valid;
    logic            timeout;

    modport master (
        output en, req, done,
        input  grant, grant_id, grant_valid, timeout
    );

    modport slave (
        input  en, req, done,
        output grant, grant_id, grant_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
//   Round-robin arbiter sharing one resource among NREQ (=8) requesters.
//   A grant is held until the owner signals done, drops its request,
//   arbitration is disabled, or the hold timer expires after MAX_HOLD cycles
//   (MAX_HOLD = 0 disables the timer). At least one idle cycle separates
//   consecutive grants. After requester i is served, the search for the
//   next owner starts at i+1, so i has the lowest priority next time.
//
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   bus   slave modport of rr_arbiter8_if:
//         en, req, done in; grant, grant_id, grant_valid, timeout out
//         (all outputs registered)
// ---------------------------------------------------------------------------
module rr_arbiter8 #(
    parameter int NREQ     = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // The counter only ever needs to reach MAX_HOLD-1; it saturates at its
    // all-ones value so it cannot wrap when the timer is disabled.
    localparam int             HCW       = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
    localparam logic [HCW-1:0] HOLD_SAT  = '1;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t          r_state;
    logic [NREQ-1:0] r_grant;
    logic [IDW-1:0]  r_grant_id;
    logic            r_grant_valid;
    logic            r_timeout;
    logic [IDW-1:0]  r_ptr;
    logic [HCW-1:0]  r_hold_cnt;

    state_t          w_state_next;
    logic [NREQ-1:0] w_grant_next;
    logic [IDW-1:0]  w_grant_id_next;
    logic            w_grant_valid_next;
    logic            w_timeout_next;
    logic [IDW-1:0]  w_ptr_next;
    logic [HCW-1:0]  w_hold_cnt_next;

    // -----------------------------------------------------------------------
    // Round-robin selection: rotate req so that bit 0 is the requester at
    // r_ptr, pick the lowest set bit, then add r_ptr back (mod 8 through
    // the natural wrap of the IDW-bit sum).
    // -----------------------------------------------------------------------
    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_first;
    logic [IDW-1:0]  w_off;
    logic [IDW-1:0]  w_sel;
    logic            w_req_any;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            assign w_rot[gi] = bus.req[r_ptr + IDW'(gi)];
            if (gi == 0) begin : g_first0
                assign w_first[gi] = w_rot[gi];
            end else begin : g_firstn
                assign w_first[gi] = w_rot[gi] & ~(|w_rot[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        w_off = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_first[i]) begin
                w_off = IDW'(i);
            end
        end
    end

    assign w_sel     = r_ptr + w_off;
    assign w_req_any = |bus.req;

    // -----------------------------------------------------------------------
    // Release conditions while a grant is held
    // -----------------------------------------------------------------------
    logic w_rel_done;
    logic w_rel_drop;
    logic w_rel_dis;
    logic w_rel_hold;
    logic w_release;

    assign w_rel_done = bus.done;
    assign w_rel_drop = ~bus.req[r_grant_id];
    assign w_rel_dis  = ~bus.en;
    assign w_rel_hold = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);
    assign w_release  = w_rel_done | w_rel_drop | w_rel_dis | w_rel_hold;

    // -----------------------------------------------------------------------
    // Next-state / next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_grant_next       = r_grant;
        w_grant_id_next    = r_grant_id;
        w_grant_valid_next = r_grant_valid;
        w_timeout_next     = 1'b0;
        w_ptr_next         = r_ptr;
        w_hold_cnt_next    = r_hold_cnt;

        case (r_state)
            ST_IDLE: begin
                w_grant_next       = '0;
                w_grant_valid_next = 1'b0;
                if (bus.en && w_req_any) begin
                    w_state_next       = ST_GRANT;
                    w_grant_id_next    = w_sel;
                    w_grant_next       = NREQ'(1) << w_sel;
                    w_grant_valid_next = 1'b1;
                    w_hold_cnt_next    = '0;
                end
            end

            ST_GRANT: begin
                if (w_release) begin
                    w_state_next       = ST_IDLE;
                    w_grant_next       = '0;
                    w_grant_valid_next = 1'b0;
                    w_ptr_next         = r_grant_id + IDW'(1);
                    // Only a pure timer expiry is reported as a timeout.
                    w_timeout_next     = w_rel_hold & ~(w_rel_done | w_rel_drop | w_rel_dis);
                end else if (r_hold_cnt != HOLD_SAT) begin
                    w_hold_cnt_next    = r_hold_cnt + HCW'(1);
                end
            end

            default: begin
                w_state_next       = ST_IDLE;
                w_grant_next       = '0;
                w_grant_valid_next = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_ptr         <= '0;
            r_hold_cnt    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_grant       <= w_grant_next;
            r_grant_id    <= w_grant_id_next;
            r_grant_valid <= w_grant_valid_next;
            r_timeout     <= w_timeout_next;
            r_ptr         <= w_ptr_next;
            r_hold_cnt    <= w_hold_cnt_next;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_id    = r_grant_id;
    assign bus.grant_valid = r_grant_valid;
    assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter8
//   Directed scenarios plus a randomized run for rr_arbiter8. Expected
//   outputs come from a behavioural model that tracks the current owner,
//   the next-search start and the number of cycles the grant has been held.
// ---------------------------------------------------------------------------
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rr_arbiter8_if #(.NREQ(8), .IDW(3)) bus ();

    rr_arbiter8 #(.NREQ(8), .IDW(3), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------
    int m_owner;    // -1 when idle
    int m_id;       // last granted index
    int m_start;    // first requester examined in the next search
    int m_held;     // cycles the current grant has been visible
    bit m_timeout;

    function automatic void model_update(input bit r, input bit e,
                                         input logic [7:0] q, input bit d);
        bit a, b, c, t;
        m_timeout = 1'b0;
        if (r) begin
            m_owner = -1; m_id = 0; m_start = 0; m_held = 0;
            return;
        end
        if (m_owner < 0) begin
            if (e && q != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    int i;
                    i = (m_start + k) % 8;
                    if (q[i]) begin
                        m_owner = i; m_id = i; m_held = 1;
                        break;
                    end
                end
            end
        end else begin
            a = d;
            b = !q[m_owner];
            c = !e;
            t = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
            if (a || b || c || t) begin
                m_timeout = t && !(a || b || c);
                m_start   = (m_owner + 1) % 8;
                m_owner   = -1;
            end else begin
                m_held++;
            end
        end
    endfunction

    // {grant, grant_id, grant_valid, timeout}
    function automatic logic [12:0] m_exp();
        logic [7:0] g;
        g = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        return {g, 3'(m_id), (m_owner >= 0) ? 1'b1 : 1'b0, m_timeout};
    endfunction

    function automatic logic [12:0] obs();
        return {bus.grant, bus.grant_id, bus.grant_valid, bus.timeout};
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic step(input bit r, input bit e, input logic [7:0] q, input bit d);
        rst      = r;
        bus.en   = e;
        bus.req  = q;
        bus.done = d;
        @(posedge clk);
        model_update(r, e, q, d);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // T1: reset holds everything low even with all requests active
    // -----------------------------------------------------------------------
    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            step(1, 1, 8'hFF, 0);
            checks++;
            if (obs() !== 13'h0000) begin
                errors++;
                $display("FAIL reset[%0d] got=%h exp=%h", n, obs(), 13'h0000);
            end
        end
        $display("reset: outputs held low");
    endtask

    // -----------------------------------------------------------------------
    // T2: single requester, grant, done, reissue one cycle later
    // -----------------------------------------------------------------------
    task automatic test_basic();
        step(0, 1, 8'h01, 0);
        checks++;
        if (bus.grant !== 8'h01 || bus.grant_id !== 3'd0 || bus.grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_grant got=%h/%0d/%b exp=01/0/1", bus.grant, bus.grant_id, bus.grant_valid);
        end
        step(0, 1, 8'h01, 1);
        checks++;
        if (bus.grant !== 8'h00 || bus.grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_release got=%h/%b exp=00/0", bus.grant, bus.grant_valid);
        end
        step(0, 1, 8'h01, 0);
        checks++;
        if (obs() !== m_exp() || bus.grant !== 8'h01) begin
            errors++;
            $display("FAIL basic_reissue got=%h exp=%h", obs(), m_exp());
        end
        $display("basic: grant id=%0d", bus.grant_id);
        step(0, 1, 8'h01, 1);
    endtask

    // -----------------------------------------------------------------------
    // T3: all requesting, done every grant -> ids 0..7,0 with gaps
    // -----------------------------------------------------------------------
    task automatic test_round_robin();
        step(1, 0, 8'h00, 0);
        for (int n = 0; n < 9; n++) begin
            step(0, 1, 8'hFF, 0);
            checks++;
            if (bus.grant_id !== 3'(n % 8) || bus.grant_valid !== 1'b1 || obs() !== m_exp()) begin
                errors++;
                $display("FAIL rr_grant[%0d] got=%h exp_id=%0d model=%h", n, obs(), n % 8, m_exp());
            end
            $display("round_robin: grant id=%0d", bus.grant_id);
            step(0, 1, 8'hFF, 1);
            checks++;
            if (bus.grant !== 8'h00 || obs() !== m_exp()) begin
                errors++;
                $display("FAIL rr_gap[%0d] got=%h exp=%h", n, obs(), m_exp());
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // T4: last served id 0, req=81 -> id 7 then wrap to id 0
    // -----------------------------------------------------------------------
    task automatic test_skip_wrap();
        step(0, 1, 8'h81, 0);
        checks++;
        if (bus.grant_id !== 3'd7 || bus.grant !== 8'h80 || obs() !== m_exp()) begin
            errors++;
            $display("FAIL skip_first got=%h exp_id=7 model=%h", obs(), m_exp());
        end
        step(0, 1, 8'h81, 1);
        step(0, 1, 8'h81, 0);
        checks++;
        if (bus.grant_id !== 3'd0 || bus.grant !== 8'h01 || obs() !== m_exp()) begin
            errors++;
            $display("FAIL skip_wrap got=%h exp_id=0 model=%h", obs(), m_exp());
        end
        $display("skip_wrap: grant id=%0d", bus.grant_id);
        step(0, 1, 8'h81, 1);
    endtask

    // -----------------------------------------------------------------------
    // T5: held request times out after exactly MAX_HOLD cycles
    // -----------------------------------------------------------------------
    task automatic test_timeout();
        int high;
        step(0, 1, 8'h04, 0);
        high = 0;
        for (int n = 0; n < 40 && bus.grant_valid === 1'b1; n++) begin
            high++;
            checks++;
            if (bus.grant !== 8'h04 || bus.timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold[%0d] got=%h/%b exp=04/0", n, bus.grant, bus.timeout);
            end
            step(0, 1, 8'h04, 0);
        end
        checks++;
        if (high !== MAX_HOLD || bus.timeout !== 1'b1 || obs() !== m_exp()) begin
            errors++;
            $display("FAIL timeout_len got=%0d cycles timeout=%b exp=%0d cycles timeout=1", high, bus.timeout, MAX_HOLD);
        end
        $display("timeout: id=2 held %0d cycles", high);
        // Search now starts at 3, so with 2 and 3 both requesting, 3 wins.
        step(0, 1, 8'h0C, 0);
        checks++;
        if (bus.grant_id !== 3'd3 || bus.timeout !== 1'b0 || obs() !== m_exp()) begin
            errors++;
            $display("FAIL timeout_ptr got=%h exp_id=3 model=%h", obs(), m_exp());
        end
    endtask

    // -----------------------------------------------------------------------
    // T6: mid-grant disable and mid-grant reset
    // -----------------------------------------------------------------------
    task automatic test_abort();
        step(0, 0, 8'h0C, 0);
        checks++;
        if (bus.grant_valid !== 1'b0 || bus.timeout !== 1'b0 || obs() !== m_exp()) begin
            errors++;
            $display("FAIL abort_en got=%h exp=%h", obs(), m_exp());
        end
        step(0, 1, 8'h0C, 0);
        checks++;
        if (bus.grant_id !== 3'd2 || obs() !== m_exp()) begin
            errors++;
            $display("FAIL abort_regrant got=%h exp_id=2 model=%h", obs(), m_exp());
        end
        step(1, 1, 8'hFF, 0);
        checks++;
        if (obs() !== 13'h0000) begin
            errors++;
            $display("FAIL abort_rst got=%h exp=%h", obs(), 13'h0000);
        end
        step(0, 1, 8'hFF, 0);
        checks++;
        if (bus.grant_id !== 3'd0 || bus.grant !== 8'h01 || obs() !== m_exp()) begin
            errors++;
            $display("FAIL abort_restart got=%h exp_id=0 model=%h", obs(), m_exp());
        end
        $display("abort: restart id=%0d", bus.grant_id);
    endtask

    // -----------------------------------------------------------------------
    // Randomized traffic against the model
    // -----------------------------------------------------------------------
    task automatic test_random();
        logic [7:0] q;
        bit         r, e, d;
        bit         prev_valid;
        q = 8'h00;
        prev_valid = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(199) == 0);
            e = ($urandom_range(31) != 0);
            d = ($urandom_range(23) == 0);
            if ($urandom_range(7) == 0) begin
                q = 8'($urandom) & 8'($urandom);
            end
            step(r, e, q, d);
            checks++;
            if (obs() !== m_exp() || !$onehot0(bus.grant)) begin
                errors++;
                $display("FAIL random[%0d] got=%h exp=%h", n, obs(), m_exp());
            end
            if (bus.grant_valid === 1'b1 && !prev_valid) begin
                $display("random: cycle %0d grant id=%0d req=%h", n, bus.grant_id, q);
            end
            if (bus.timeout === 1'b1) begin
                $display("random: cycle %0d timeout", n);
            end
            prev_valid = (bus.grant_valid === 1'b1);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        m_owner  = -1;
        m_id     = 0;
        m_start  = 0;
        m_held   = 0;
        m_timeout = 1'b0;
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_round_robin();
        test_skip_wrap();
        test_timeout();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
